// File: rtl/arashi_mtq.sv
// Multi-thread queue engine: one shared register array split into per-thread circular FIFOs,
// with round-robin push and pop arbiters. Define ARASHI_MTQ_ERR_EN to add the sticky err_o port.
module arashi_mtq #(
    parameter int DATA_WIDTH       = 32,
    parameter int MEM_WIDTH        = 10,
    parameter int THREAD_NUM_WIDTH = 2
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic [2*(1<<THREAD_NUM_WIDTH)-1:0]             ctrl_i,
    input  logic [DATA_WIDTH*(1<<THREAD_NUM_WIDTH)-1:0]    data_in_i,
    output logic [DATA_WIDTH*(1<<THREAD_NUM_WIDTH)-1:0]    data_out_o,
    output logic [(1<<THREAD_NUM_WIDTH)-1:0]               w_gnt_o,
    output logic [(1<<THREAD_NUM_WIDTH)-1:0]               r_gnt_o,
    output logic [(1<<THREAD_NUM_WIDTH)-1:0]               r_valid_o,
    output logic [(1<<THREAD_NUM_WIDTH)-1:0]               avail_o,
    output logic [(1<<THREAD_NUM_WIDTH)-1:0]               full_o
`ifdef ARASHI_MTQ_ERR_EN
    ,
    output logic [(1<<THREAD_NUM_WIDTH)-1:0]               err_o
`endif
);

    localparam int THREAD_NUM = 1 << THREAD_NUM_WIDTH;
    localparam int PTR_W      = (MEM_WIDTH > THREAD_NUM_WIDTH) ? (MEM_WIDTH - THREAD_NUM_WIDTH) : 1;
    localparam int DEPTH      = 1 << PTR_W;
    localparam int CNT_W      = PTR_W + 1;
    localparam int TID_W      = (THREAD_NUM_WIDTH > 0) ? THREAD_NUM_WIDTH : 1;
    localparam int WORDS      = THREAD_NUM * DEPTH;

    if (THREAD_NUM_WIDTH > 4 || MEM_WIDTH <= THREAD_NUM_WIDTH) begin : g_param_check
        $error("arashi_mtq: THREAD_NUM_WIDTH must be 0..4 and MEM_WIDTH must exceed it");
    end

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic [CNT_W-1:0]      cnt_q     [THREAD_NUM];
    logic [CNT_W-1:0]      cnt_d     [THREAD_NUM];
    logic [PTR_W-1:0]      wrPtr_q   [THREAD_NUM];
    logic [PTR_W-1:0]      wrPtr_d   [THREAD_NUM];
    logic [PTR_W-1:0]      rdPtr_q   [THREAD_NUM];
    logic [PTR_W-1:0]      rdPtr_d   [THREAD_NUM];
    logic [DATA_WIDTH-1:0] dataOut_q [THREAD_NUM];
    logic [DATA_WIDTH-1:0] dataOut_d [THREAD_NUM];

    logic [THREAD_NUM-1:0] avail_q, avail_d;
    logic [THREAD_NUM-1:0] full_q, full_d;
    logic [THREAD_NUM-1:0] rValid_q, rValid_d;
    logic [THREAD_NUM-1:0] pushEl, popEl;

    logic [TID_W-1:0]      wRr_q, wRr_d, rRr_q, rRr_d;
    logic [TID_W-1:0]      wSel, rSel, wCand, rCand;
    logic                  wAny, rAny;

    logic [MEM_WIDTH-1:0]  wAddr, rAddr;
    logic [DATA_WIDTH-1:0] wData, rdWord;

    // 2'b11 is neither push nor pop; eligibility looks only at registered full/avail.
    always_comb begin
        pushEl = '0;
        popEl  = '0;
        for (int t = 0; t < THREAD_NUM; t++) begin
            pushEl[t] = ctrl_i[2*t+1] && !ctrl_i[2*t] && !full_q[t];
            popEl[t]  = ctrl_i[2*t] && !ctrl_i[2*t+1] && avail_q[t];
        end
    end

    always_comb begin
        w_gnt_o = '0;
        r_gnt_o = '0;
        wSel    = '0;
        rSel    = '0;
        wCand   = '0;
        rCand   = '0;
        wAny    = 1'b0;
        rAny    = 1'b0;
        for (int i = 0; i < THREAD_NUM; i++) begin
            wCand = wRr_q + TID_W'(i);
            rCand = rRr_q + TID_W'(i);
            if (!wAny && pushEl[wCand]) begin
                wAny = 1'b1;
                wSel = wCand;
            end
            if (!rAny && popEl[rCand]) begin
                rAny = 1'b1;
                rSel = rCand;
            end
        end
        if (wAny) begin
            w_gnt_o[wSel] = 1'b1;
        end
        if (rAny) begin
            r_gnt_o[rSel] = 1'b1;
        end
        wRr_d = wRr_q;
        rRr_d = rRr_q;
        if (wAny) begin
            wRr_d = (THREAD_NUM == 1) ? '0 : wSel + TID_W'(1);
        end
        if (rAny) begin
            rRr_d = (THREAD_NUM == 1) ? '0 : rSel + TID_W'(1);
        end
    end

    // Flat storage address is {thread, per-thread pointer}.
    always_comb begin
        wAddr  = (MEM_WIDTH'(wSel) << PTR_W) | MEM_WIDTH'(wrPtr_q[wSel]);
        rAddr  = (MEM_WIDTH'(rSel) << PTR_W) | MEM_WIDTH'(rdPtr_q[rSel]);
        rdWord = mem[rAddr];
        wData  = '0;
        for (int t = 0; t < THREAD_NUM; t++) begin
            if (w_gnt_o[t]) begin
                wData = data_in_i[t*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        rValid_d = r_gnt_o;
        avail_d  = '0;
        full_d   = '0;
        for (int t = 0; t < THREAD_NUM; t++) begin
            cnt_d[t]     = cnt_q[t] + CNT_W'(w_gnt_o[t]) - CNT_W'(r_gnt_o[t]);
            wrPtr_d[t]   = wrPtr_q[t] + PTR_W'(w_gnt_o[t]);
            rdPtr_d[t]   = rdPtr_q[t] + PTR_W'(r_gnt_o[t]);
            dataOut_d[t] = r_gnt_o[t] ? rdWord : dataOut_q[t];
            avail_d[t]   = (cnt_d[t] != '0);
            full_d[t]    = (cnt_d[t] == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int t = 0; t < THREAD_NUM; t++) begin
                cnt_q[t]     <= '0;
                wrPtr_q[t]   <= '0;
                rdPtr_q[t]   <= '0;
                dataOut_q[t] <= '0;
            end
            avail_q  <= '0;
            full_q   <= '0;
            rValid_q <= '0;
            wRr_q    <= '0;
            rRr_q    <= '0;
        end else begin
            for (int t = 0; t < THREAD_NUM; t++) begin
                cnt_q[t]     <= cnt_d[t];
                wrPtr_q[t]   <= wrPtr_d[t];
                rdPtr_q[t]   <= rdPtr_d[t];
                dataOut_q[t] <= dataOut_d[t];
            end
            avail_q  <= avail_d;
            full_q   <= full_d;
            rValid_q <= rValid_d;
            wRr_q    <= wRr_d;
            rRr_q    <= rRr_d;
        end
    end

    // Storage is not reset; the pointers define which words are meaningful.
    always_ff @(posedge clk_i) begin
        if (wAny && !rst_i) begin
            mem[wAddr] <= wData;
        end
    end

`ifdef ARASHI_MTQ_ERR_EN
    logic [THREAD_NUM-1:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        for (int t = 0; t < THREAD_NUM; t++) begin
            if (ctrl_i[2*t+1] && ctrl_i[2*t]) begin
                err_d[t] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

    for (genvar g = 0; g < THREAD_NUM; g++) begin : g_out
        assign data_out_o[g*DATA_WIDTH +: DATA_WIDTH] = dataOut_q[g];
    end

    assign r_valid_o = rValid_q;
    assign avail_o   = avail_q;
    assign full_o    = full_q;

endmodule

// File: tb/tb_arashi_mtq.sv
// Directed bench for arashi_mtq with 4 threads of depth 4 (MEM_WIDTH=4).
// Define ARASHI_MTQ_ERR_EN to also check the sticky err_o flags.
module tb_arashi_mtq;

    localparam int DW = 32;
    localparam int TN = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [2*TN-1:0]  ctrl;
    logic [DW*TN-1:0] dataIn;
    logic [DW*TN-1:0] dataOut;
    logic [TN-1:0]    wGnt, rGnt, rValid, avail, full;
`ifdef ARASHI_MTQ_ERR_EN
    logic [TN-1:0]    err;
`endif

    int checkCount = 0;
    int errorCount = 0;

    arashi_mtq #(
        .DATA_WIDTH       (DW),
        .MEM_WIDTH        (4),
        .THREAD_NUM_WIDTH (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ctrl_i     (ctrl),
        .data_in_i  (dataIn),
        .data_out_o (dataOut),
        .w_gnt_o    (wGnt),
        .r_gnt_o    (rGnt),
        .r_valid_o  (rValid),
        .avail_o    (avail),
        .full_o     (full)
`ifdef ARASHI_MTQ_ERR_EN
        ,
        .err_o      (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2*TN-1:0] c);
        ctrl = c;
        #1;
    endtask

    task automatic setData(input int t, input logic [31:0] d);
        dataIn[t*DW +: DW] = d;
    endtask

    function automatic logic [31:0] outWord(input int t);
        return dataOut[t*DW +: DW];
    endfunction

    task automatic doReset();
        rst  = 1'b1;
        ctrl = '0;
        tick();
        tick();
        rst  = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        ctrl   = '1;
        dataIn = '0;

        // T1: reset with all-ones ctrl
        tick();
        tick();
        checkOutput("t1_wgnt_rst", 32'(wGnt), 32'h0);
        checkOutput("t1_rgnt_rst", 32'(rGnt), 32'h0);
        checkOutput("t1_avail_rst", 32'(avail), 32'h0);
        checkOutput("t1_full_rst", 32'(full), 32'h0);
        checkOutput("t1_rvalid_rst", 32'(rValid), 32'h0);
        ctrl = '0;
        rst  = 1'b0;
        tick();
        checkOutput("t1_dataout", dataOut[31:0] | dataOut[63:32] | dataOut[95:64] | dataOut[127:96], 32'h0);
        checkOutput("t1_avail", 32'(avail), 32'h0);
`ifdef ARASHI_MTQ_ERR_EN
        checkOutput("t1_err", 32'(err), 32'h0);
`endif

        // T2: single push then pop on thread 1
        setData(1, 32'hDEADBEEF);
        applyStimulus(8'b0000_1000);
        checkOutput("t2_wgnt", 32'(wGnt), 32'h2);
        tick();
        applyStimulus(8'h00);
        checkOutput("t2_avail", 32'(avail), 32'h2);
        checkOutput("t2_full", 32'(full), 32'h0);
        applyStimulus(8'b0000_0100);
        checkOutput("t2_rgnt", 32'(rGnt), 32'h2);
        checkOutput("t2_rvalid_early", 32'(rValid), 32'h0);
        tick();
        applyStimulus(8'h00);
        checkOutput("t2_rvalid", 32'(rValid), 32'h2);
        checkOutput("t2_data", outWord(1), 32'hDEADBEEF);
        checkOutput("t2_avail_empty", 32'(avail), 32'h0);
        tick();
        checkOutput("t2_rvalid_pulse", 32'(rValid), 32'h0);
        checkOutput("t2_data_hold", outWord(1), 32'hDEADBEEF);

        // T3: all four threads hold push for 8 cycles
        doReset();
        for (int k = 0; k < 8; k++) begin
            for (int t = 0; t < TN; t++) begin
                setData(t, 32'h3000_0000 + 32'(t * 16 + k));
            end
            applyStimulus(8'hAA);
            checkOutput($sformatf("t3_wgnt%0d", k), 32'(wGnt), 32'(1 << (k % 4)));
            tick();
        end
        applyStimulus(8'h00);
        checkOutput("t3_avail", 32'(avail), 32'hF);
        checkOutput("t3_full", 32'(full), 32'h0);
        applyStimulus(8'h01);
        checkOutput("t3_rgnt0", 32'(rGnt), 32'h1);
        tick();
        checkOutput("t3_pop0", outWord(0), 32'h3000_0000);
        checkOutput("t3_rgnt1", 32'(rGnt), 32'h1);
        tick();
        applyStimulus(8'h00);
        checkOutput("t3_pop1", outWord(0), 32'h3000_0004);
        checkOutput("t3_avail_after", 32'(avail), 32'hE);

        // T4: thread 2 fills, holds, wraps
        doReset();
        applyStimulus(8'b0010_0000);
        for (int v = 1; v <= 4; v++) begin
            setData(2, 32'(v));
            #1;
            checkOutput($sformatf("t4_wgnt%0d", v), 32'(wGnt), 32'h4);
            tick();
        end
        setData(2, 32'd5);
        #1;
        checkOutput("t4_full", 32'(full), 32'h4);
        checkOutput("t4_held", 32'(wGnt), 32'h0);
        tick();
        checkOutput("t4_held2", 32'(wGnt), 32'h0);
        applyStimulus(8'b0001_0000);
        checkOutput("t4_rgnt", 32'(rGnt), 32'h4);
        tick();
        checkOutput("t4_pop1", outWord(2), 32'd1);
        checkOutput("t4_notfull", 32'(full), 32'h0);
        applyStimulus(8'b0010_0000);
        checkOutput("t4_wgnt5", 32'(wGnt), 32'h4);
        tick();
        checkOutput("t4_full2", 32'(full), 32'h4);
        applyStimulus(8'b0001_0000);
        for (int v = 2; v <= 5; v++) begin
            checkOutput($sformatf("t4_rgnt%0d", v), 32'(rGnt), 32'h4);
            tick();
            checkOutput($sformatf("t4_rvalid%0d", v), 32'(rValid), 32'h4);
            checkOutput($sformatf("t4_pop%0d", v), outWord(2), 32'(v));
        end
        checkOutput("t4_empty", 32'(avail), 32'h0);
        checkOutput("t4_no_underflow", 32'(rGnt), 32'h0);
        applyStimulus(8'h00);

        // T5: push/pop on thread 0 in separate cycles, then pop0 with push3 together
        doReset();
        setData(0, 32'hA0);
        applyStimulus(8'h02);
        checkOutput("t5_wgntA", 32'(wGnt), 32'h1);
        tick();
        setData(0, 32'hB0);
        #1;
        checkOutput("t5_wgntB", 32'(wGnt), 32'h1);
        tick();
        setData(0, 32'hC0);
        #1;
        checkOutput("t5_wgntC", 32'(wGnt), 32'h1);
        tick();
        applyStimulus(8'h01);
        checkOutput("t5_rgnt", 32'(rGnt), 32'h1);
        tick();
        checkOutput("t5_popA", outWord(0), 32'hA0);
        setData(3, 32'h33);
        applyStimulus(8'h81);
        checkOutput("t5_both_r", 32'(rGnt), 32'h1);
        checkOutput("t5_both_w", 32'(wGnt), 32'h8);
        tick();
        checkOutput("t5_popB", outWord(0), 32'hB0);
        checkOutput("t5_avail", 32'(avail), 32'h9);
        applyStimulus(8'h41);
        checkOutput("t5_rr_r3", 32'(rGnt), 32'h8);
        tick();
        checkOutput("t5_pop3", outWord(3), 32'h33);
        checkOutput("t5_rvalid3", 32'(rValid), 32'h8);
        checkOutput("t5_rr_r0", 32'(rGnt), 32'h1);
        tick();
        applyStimulus(8'h00);
        checkOutput("t5_popC", outWord(0), 32'hC0);
        checkOutput("t5_drained", 32'(avail), 32'h0);

        // T6: illegal ctrl, then reset in the cycle of a pop grant
        doReset();
        applyStimulus(8'h03);
        checkOutput("t6_illegal_w", 32'(wGnt), 32'h0);
        checkOutput("t6_illegal_r", 32'(rGnt), 32'h0);
        tick();
        applyStimulus(8'h00);
`ifdef ARASHI_MTQ_ERR_EN
        checkOutput("t6_err_set", 32'(err), 32'h1);
`endif
        setData(1, 32'h66);
        applyStimulus(8'h08);
        checkOutput("t6_wgnt", 32'(wGnt), 32'h2);
        tick();
        applyStimulus(8'h04);
        checkOutput("t6_rgnt", 32'(rGnt), 32'h2);
        rst = 1'b1;
        tick();
        checkOutput("t6_rvalid_rst", 32'(rValid), 32'h0);
        checkOutput("t6_avail_rst", 32'(avail), 32'h0);
`ifdef ARASHI_MTQ_ERR_EN
        checkOutput("t6_err_clr", 32'(err), 32'h0);
`endif
        rst = 1'b0;
        applyStimulus(8'h00);
        tick();
        checkOutput("t6_rvalid_after", 32'(rValid), 32'h0);
        checkOutput("t6_avail_after", 32'(avail), 32'h0);
        checkOutput("t6_data_after", outWord(1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
